sr_pulse_driver: RTL and testbench

- Synchronous stimulus generator for the cross-coupled SR latch. It is the driving end of the latch's set/reset interface.
- Accepts a command over a valid/ready handshake, then emits N active-low pulses on either set_n or reset_n, separated by idle gaps.
- Samples the latch's q output after each pulse and flags any mismatch.
- Sits between control logic or a bench sequencer and an SR_latch instance.

---
 rtl/sr_pkg.sv | 6 +
 rtl/sr_cycle_timer.sv | 17 +
 rtl/sr_pulse_driver.sv | 95 +++++++++
 tb/tb_sr_pulse_driver.sv | 119 +++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// sr_pkg: shared state encoding and command opcodes for the SR latch driver.
package sr_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;
  localparam logic OP_RESET = 1'b0;
  localparam logic OP_SET   = 1'b1;
endpackage

// File: rtl/sr_cycle_timer.sv
// sr_cycle_timer: loadable down-counter; tc_o is high while the count sits at zero.
module sr_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc_o = cnt_q == '0;
endmodule

// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: emits N active-low pulses on set_n or reset_n per command
// and checks the latch q after every pulse.
module sr_pulse_driver import sr_pkg::*; #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             set_n,
  output logic             reset_n,
  input  logic             q_sense,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             set_n_q, reset_n_q, busy_q, done_q;
  logic             ld, tc, accept;
  logic [CNT_W-1:0] ld_val;
  assign cmd_ready = (state_q == IDLE) & ~reset;
  assign accept    = cmd_valid & cmd_ready;
  sr_cycle_timer #(.W(CNT_W)) u_timer (
    .clk_i  (clock),
    .rst_i  (reset),
    .load_i (ld),
    .val_i  (ld_val),
    .tc_o   (tc)
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    err_d   = err_q;
    ld      = 1'b0;
    ld_val  = PULSE_LD;
    case (state_q)
      IDLE: if (accept) begin
        op_d    = cmd_op;
        rem_d   = cmd_count;
        err_d   = 1'b0;
        ld      = 1'b1;
        state_d = cmd_count != '0 ? PULSE : DONE;
      end
      PULSE: if (tc) begin
        ld      = 1'b1;
        ld_val  = GAP_LD;
        state_d = GAP;
      end
      GAP: if (tc) begin
        // Last gap cycle: the latch has settled, so q must equal the op just driven.
        err_d   = err_q | (q_sense != op_q);
        rem_d   = rem_q - 1'b1;
        ld      = 1'b1;
        state_d = rem_q == CNT_W'(1) ? DONE : PULSE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Drives are registered from the next state so they change with the state itself.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_RESET;
      rem_q     <= '0;
      err_q     <= 1'b0;
      set_n_q   <= 1'b1;
      reset_n_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      set_n_q   <= !(state_d == PULSE && op_d == OP_SET);
      reset_n_q <= !(state_d == PULSE && op_d == OP_RESET);
      busy_q    <= state_d != IDLE;
      done_q    <= state_d == DONE;
    end
  assign set_n   = set_n_q;
  assign reset_n = reset_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver: directed commands against a behavioural SR latch, with a
// per-cycle expected-trace scoreboard filled at command issue.
module tb_sr_pulse_driver;
  localparam int P = 4;
  localparam int G = 2;
  localparam int W = 8;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_op = 1'b0;
  logic [W-1:0] cmd_count = '0;
  logic         q_force = 1'b0;
  logic         latch_q = 1'b0;
  logic         cmd_ready, set_n, reset_n, busy, done, err, q_sense;
  int           total = 0;
  int           bad = 0;
  logic [4:0]   exp_q[$];

  sr_pulse_driver #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .CNT_W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .set_n     (set_n),
    .reset_n   (reset_n),
    .q_sense   (q_sense),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  always @(set_n or reset_n)
    if (set_n === 1'b0) latch_q = 1'b1;
    else if (reset_n === 1'b0) latch_q = 1'b0;

  assign q_sense = q_force ? 1'b0 : latch_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issues one command and checks {set_n,reset_n,done,err,busy} every cycle until done.
  task automatic run_cmd(input logic op, input int n, input logic mis, input logic hold);
    int len;
    logic [4:0] e;
    len = n * (P + G) + 1;
    @(negedge clock);
    chk("ready_before", cmd_ready, 1);
    cmd_op = op;
    cmd_count = W'(n);
    cmd_valid = 1'b1;
    for (int k = 1; k <= len; k++) begin
      int ph;
      logic lo;
      ph = (k - 1) % (P + G);
      lo = (k < len) && (ph < P);
      exp_q.push_back({!(lo && op), !(lo && !op), k == len, mis && (k > P + G), 1'b1});
    end
    for (int k = 1; k <= len; k++) begin
      @(negedge clock);
      if (!hold) cmd_valid = 1'b0;
      chk("ready_busy", cmd_ready, 0);
      e = exp_q.pop_front();
      chk("trace", {set_n, reset_n, done, err, busy}, e);
    end
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("ready_after", cmd_ready, 1);
    chk("done_clear", done, 0);
    chk("err_after", err, mis && n > 0);
  endtask

  initial begin
    repeat (3) begin
      @(negedge clock);
      chk("rst_vals", {set_n, reset_n, busy, err, done, cmd_ready}, 6'b110000);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("ready_post_rst", {cmd_ready, busy}, 2'b10);
    run_cmd(1'b1, 1, 1'b0, 1'b0);
    run_cmd(1'b0, 3, 1'b0, 1'b0);
    q_force = 1'b1;
    run_cmd(1'b1, 2, 1'b1, 1'b0);
    q_force = 1'b0;
    run_cmd(1'b1, 1, 1'b0, 1'b0);
    run_cmd(1'b0, 0, 1'b0, 1'b0);
    run_cmd(1'b1, 1, 1'b0, 1'b1);
    @(negedge clock);
    cmd_op = 1'b1;
    cmd_count = W'(3);
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("mid_pulse1", {set_n, reset_n}, 2'b01);
    @(negedge clock);
    chk("mid_pulse2", {set_n, reset_n}, 2'b01);
    #2 reset = 1'b1;
    #1 chk("rst_async", {set_n, reset_n, busy, cmd_ready}, 4'b1100);
    repeat (2) begin
      @(negedge clock);
      chk("rst_hold", {set_n, reset_n, done, busy}, 4'b1100);
    end
    reset = 1'b0;
    #1 chk("ready_rst_exit", cmd_ready, 1);
    run_cmd(1'b0, 1, 1'b0, 1'b0);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
